bus_endpoint_fifo: RTL

Device-side endpoint for the `bs_gnrtr_n_rbtr` bus; one instance per device port.
- TX path: local writes are buffered and presented to the bus as a pending, show-ahead FIFO on `pndng`/`D_pop`, drained by the bus `pop`.
- RX path: packets the bus delivers on `push`/`D_push` are filtered by destination ID (own ID or broadcast), then buffered for the local reader.
- Replaces the behavioural FIFO emulation in the driver/monitor with synthesizable RTL.

---
 rtl/bus_endpoint_fifo.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bus_endpoint_fifo.sv
// Device-side bus endpoint: a show-ahead TX FIFO drained by the bus, and an
// ID-filtered RX FIFO filled by the bus and drained by the local reader.
module bus_endpoint_fifo #(
    parameter int unsigned pckg_sz   = 16,
    parameter int unsigned depth     = 8,
    parameter logic [7:0]  id        = 8'd0,
    parameter logic [7:0]  broadcast = {8{1'b1}}
) (
    input  logic                       clk,
    input  logic                       reset,
    // Local TX side
    input  logic                       tx_wr,
    input  logic [pckg_sz-1:0]         tx_data,
    output logic                       tx_full,
    // Bus pop side
    output logic                       pndng,
    output logic [pckg_sz-1:0]         D_pop,
    input  logic                       pop,
    // Bus push side
    input  logic                       push,
    input  logic [pckg_sz-1:0]         D_push,
    // Local RX side
    output logic                       rx_valid,
    output logic [pckg_sz-1:0]         rx_data,
    input  logic                       rx_rd,
    // Status
    output logic [$clog2(depth):0]     tx_count,
    output logic [$clog2(depth):0]     rx_count,
    output logic [7:0]                 rx_ovf_cnt,
    output logic [7:0]                 rx_mis_cnt
);

    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned PW = AW + 1;

    // ---------------------------------------------------------------- TX path
    logic [pckg_sz-1:0] tx_mem [depth];
    logic [PW-1:0]      tx_wptr_q, tx_wptr_d;
    logic [PW-1:0]      tx_rptr_q, tx_rptr_d;
    logic [PW-1:0]      tx_cnt_q, tx_cnt_d;
    logic               tx_empty, tx_full_w, tx_pop_ok, tx_wr_ok;

    // TX pointer/occupancy next state; a pop frees the slot a full-FIFO write needs.
    always_comb begin
        tx_empty  = (tx_wptr_q == tx_rptr_q);
        tx_full_w = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                    (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
        tx_pop_ok = pop && !tx_empty;
        tx_wr_ok  = tx_wr && (!tx_full_w || tx_pop_ok);
        tx_wptr_d = tx_wptr_q + PW'(tx_wr_ok);
        tx_rptr_d = tx_rptr_q + PW'(tx_pop_ok);
        tx_cnt_d  = tx_cnt_q + PW'(tx_wr_ok) - PW'(tx_pop_ok);
    end

    // TX pointer and count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
        end
    end

    // TX storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (tx_wr_ok) begin
            tx_mem[tx_wptr_q[AW-1:0]] <= tx_data;
        end
    end

    assign pndng    = !tx_empty;
    assign tx_full  = tx_full_w;
    assign D_pop    = tx_mem[tx_rptr_q[AW-1:0]];
    assign tx_count = tx_cnt_q;

    // ---------------------------------------------------------------- RX path
    logic [pckg_sz-1:0] rx_mem [depth];
    logic [PW-1:0]      rx_wptr_q, rx_wptr_d;
    logic [PW-1:0]      rx_rptr_q, rx_rptr_d;
    logic [PW-1:0]      rx_cnt_q, rx_cnt_d;
    logic [7:0]         rx_ovf_q, rx_ovf_d;
    logic [7:0]         rx_mis_q, rx_mis_d;
    logic [7:0]         rx_dst;
    logic               rx_empty, rx_full_w, rx_rd_ok, rx_match, rx_wr_ok;

    // RX filter, pointer/occupancy and saturating drop-counter next state.
    always_comb begin
        rx_dst    = D_push[pckg_sz-1 -: 8];
        rx_match  = (rx_dst == id) || (rx_dst == broadcast);
        rx_empty  = (rx_wptr_q == rx_rptr_q);
        rx_full_w = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                    (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
        rx_rd_ok  = rx_rd && !rx_empty;
        rx_wr_ok  = push && rx_match && (!rx_full_w || rx_rd_ok);
        rx_wptr_d = rx_wptr_q + PW'(rx_wr_ok);
        rx_rptr_d = rx_rptr_q + PW'(rx_rd_ok);
        rx_cnt_d  = rx_cnt_q + PW'(rx_wr_ok) - PW'(rx_rd_ok);
        rx_ovf_d  = rx_ovf_q;
        rx_mis_d  = rx_mis_q;
        if (push && rx_match && !rx_wr_ok && (rx_ovf_q != 8'hFF)) begin
            rx_ovf_d = rx_ovf_q + 8'd1;
        end
        if (push && !rx_match && (rx_mis_q != 8'hFF)) begin
            rx_mis_d = rx_mis_q + 8'd1;
        end
    end

    // RX pointer, count and drop-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            rx_ovf_q  <= '0;
            rx_mis_q  <= '0;
        end else begin
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_ovf_q  <= rx_ovf_d;
            rx_mis_q  <= rx_mis_d;
        end
    end

    // RX storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (rx_wr_ok) begin
            rx_mem[rx_wptr_q[AW-1:0]] <= D_push;
        end
    end

    assign rx_valid   = !rx_empty;
    assign rx_data    = rx_mem[rx_rptr_q[AW-1:0]];
    assign rx_count   = rx_cnt_q;
    assign rx_ovf_cnt = rx_ovf_q;
    assign rx_mis_cnt = rx_mis_q;

endmodule
